// File: rtl/vram_pkg.sv
// Shared types and helpers for the dual-port video RAM.
package vram_pkg;

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} scan_state_e;

  // Widest word be_merge handles; callers zero-extend their operands and truncate the result.
  localparam int unsigned MaxDataWidth = 256;
  localparam int unsigned MaxBe        = MaxDataWidth / 8;

  function automatic int unsigned read_lat(input int unsigned out_reg);
    return (out_reg != 0) ? 2 : 1;
  endfunction

  // One slot per read in flight, plus one so a stalled head never blocks a full-rate stream.
  function automatic int unsigned fifo_depth(input int unsigned out_reg);
    return read_lat(out_reg) + 1;
  endfunction

  function automatic logic [MaxDataWidth-1:0] be_merge(input logic [MaxDataWidth-1:0] old_word,
                                                       input logic [MaxDataWidth-1:0] new_word,
                                                       input logic [MaxBe-1:0]        be);
    logic [MaxDataWidth-1:0] res;
    res = old_word;
    for (int i = 0; i < int'(MaxBe); i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/vram_scan_fifo.sv
// Small synchronous FIFO holding scanout read data so backpressure never drops a word.
module vram_scan_fifo
  import vram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           flush,
  input  logic                           push,
  input  logic [DATA_WIDTH-1:0]          push_data,
  input  logic                           pop,
  output logic [DATA_WIDTH-1:0]          pop_data,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Storage, pointers and occupancy; flush empties the queue without touching storage.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/vram_dual_port.sv
// Dual-port video RAM: CPU read/write port with byte enables, plus a read-only scanout burst
// engine streaming words to the renderer over valid/ready.
module vram_dual_port
  import vram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_BITS  = 10,
  parameter int unsigned OUT_REG    = 0
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [DATA_WIDTH/8-1:0] cpu_be,
  input  logic [ADDR_BITS-1:0]    cpu_addr,
  input  logic [DATA_WIDTH-1:0]   cpu_data_in,
  output logic [DATA_WIDTH-1:0]   cpu_data_out,
  output logic                    cpu_ack,
  input  logic                    scan_start,
  input  logic                    scan_abort,
  input  logic [ADDR_BITS-1:0]    scan_base,
  input  logic [ADDR_BITS:0]      scan_count,
  output logic [DATA_WIDTH-1:0]   scan_data,
  output logic                    scan_valid,
  input  logic                    scan_ready,
  output logic                    scan_busy,
  output logic                    scan_done
);

  localparam int unsigned FifoDepth = fifo_depth(OUT_REG);
  localparam int unsigned CntW      = $clog2(FifoDepth + 1);
  localparam int unsigned OccW      = CntW + 1;
  localparam int unsigned CntBits   = ADDR_BITS + 1;
  localparam int unsigned Depth     = 2 ** ADDR_BITS;

  logic [DATA_WIDTH-1:0] mem [Depth];

  logic [DATA_WIDTH-1:0] old_a, merged_a, rd_b;
  logic                  wr_a;
  scan_state_e           state_q;
  logic [ADDR_BITS-1:0]  scan_addr_q;
  logic [CntBits-1:0]    remaining_q;
  logic                  done_q;
  logic                  a_vld_q, b_vld_q;
  logic [DATA_WIDTH-1:0] a_data_q, b_data_q;
  logic                  push, pop, issue;
  logic [DATA_WIDTH-1:0] push_data;
  logic [CntW-1:0]       fifo_count;
  logic [OccW-1:0]       inflight, occ;

  // Port A merge and port B read with same-cycle write bypass; occ counts words owed downstream.
  always_comb begin
    old_a    = mem[cpu_addr];
    wr_a     = cpu_req & cpu_we;
    merged_a = DATA_WIDTH'(be_merge(MaxDataWidth'(old_a), MaxDataWidth'(cpu_data_in),
                                    MaxBe'(cpu_be)));
    rd_b     = (wr_a && (cpu_addr == scan_addr_q)) ? merged_a : mem[scan_addr_q];
    pop      = scan_valid & scan_ready;
    occ      = OccW'(fifo_count) + inflight - OccW'(pop);
    issue    = (state_q == StFetch) && (remaining_q != '0) && (occ < OccW'(FifoDepth)) &&
               !scan_abort;
  end

  // Memory array; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_a) mem[cpu_addr] <= merged_a;
  end

  // First read stage of both ports; CPU data only moves on a request so it holds between acks.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_vld_q  <= 1'b0;
      a_data_q <= '0;
      b_vld_q  <= 1'b0;
      b_data_q <= '0;
    end else begin
      a_vld_q <= cpu_req;
      if (cpu_req) a_data_q <= cpu_we ? merged_a : old_a;
      b_vld_q <= issue;
      if (issue) b_data_q <= rd_b;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic                  a2_vld_q, b2_vld_q;
    logic [DATA_WIDTH-1:0] a2_data_q, b2_data_q;

    // Optional second read stage; an abort drops the read sitting in it.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        a2_vld_q  <= 1'b0;
        a2_data_q <= '0;
        b2_vld_q  <= 1'b0;
        b2_data_q <= '0;
      end else begin
        a2_vld_q <= a_vld_q;
        if (a_vld_q) a2_data_q <= a_data_q;
        b2_vld_q <= b_vld_q & ~scan_abort;
        if (b_vld_q) b2_data_q <= b_data_q;
      end
    end

    assign cpu_ack      = a2_vld_q;
    assign cpu_data_out = a2_data_q;
    assign push         = b2_vld_q;
    assign push_data    = b2_data_q;
    assign inflight     = OccW'(b_vld_q) + OccW'(b2_vld_q);
  end else begin : g_no_out_reg
    assign cpu_ack      = a_vld_q;
    assign cpu_data_out = a_data_q;
    assign push         = b_vld_q;
    assign push_data    = b_data_q;
    assign inflight     = OccW'(b_vld_q);
  end

  vram_scan_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (FifoDepth)
  ) u_scan_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (scan_abort),
    .push     (push),
    .push_data(push_data),
    .pop      (pop),
    .pop_data (scan_data),
    .count    (fifo_count)
  );

  // Scan burst FSM; abort takes priority over everything, including a start.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      scan_addr_q <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (scan_abort) begin
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (scan_start) begin
              scan_addr_q <= scan_base;
              remaining_q <= scan_count;
              if (scan_count == '0) done_q  <= 1'b1;
              else                  state_q <= StFetch;
            end
          end
          StFetch: begin
            if (issue) begin
              scan_addr_q <= scan_addr_q + ADDR_BITS'(1);
              remaining_q <= remaining_q - CntBits'(1);
              if (remaining_q == CntBits'(1)) state_q <= StDrain;
            end
          end
          StDrain: begin
            // Fires on the edge of the final handshake so DONE shows the following cycle.
            if (occ == '0) begin
              done_q  <= 1'b1;
              state_q <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign scan_valid = (fifo_count != '0);
  assign scan_busy  = (state_q != StIdle);
  assign scan_done  = done_q;

endmodule

// File: tb/tb_vram_dual_port.sv
// Directed bench for vram_dual_port; drives one DUT per OUT_REG setting from shared stimulus.
module tb_vram_dual_port;

  localparam int unsigned DW = 16;
  localparam int unsigned AB = 10;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cpu_req, cpu_we;
  logic [1:0]    cpu_be;
  logic [AB-1:0] cpu_addr;
  logic [DW-1:0] cpu_data_in;
  logic          scan_start, scan_abort, scan_ready;
  logic [AB-1:0] scan_base;
  logic [AB:0]   scan_count;

  logic [DW-1:0] cpu_data_out [2];
  logic          cpu_ack      [2];
  logic [DW-1:0] scan_data    [2];
  logic          scan_valid   [2];
  logic          scan_busy    [2];
  logic          scan_done    [2];

  vram_dual_port #(.DATA_WIDTH(DW), .ADDR_BITS(AB), .OUT_REG(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be),
    .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out[0]),
    .cpu_ack(cpu_ack[0]), .scan_start(scan_start), .scan_abort(scan_abort),
    .scan_base(scan_base), .scan_count(scan_count), .scan_data(scan_data[0]),
    .scan_valid(scan_valid[0]), .scan_ready(scan_ready), .scan_busy(scan_busy[0]),
    .scan_done(scan_done[0])
  );

  vram_dual_port #(.DATA_WIDTH(DW), .ADDR_BITS(AB), .OUT_REG(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be),
    .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out[1]),
    .cpu_ack(cpu_ack[1]), .scan_start(scan_start), .scan_abort(scan_abort),
    .scan_base(scan_base), .scan_count(scan_count), .scan_data(scan_data[1]),
    .scan_valid(scan_valid[1]), .scan_ready(scan_ready), .scan_busy(scan_busy[1]),
    .scan_done(scan_done[1])
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;
  int t0     = 0;

  // Stream monitor, sampled mid-cycle.
  logic [DW-1:0] words [2][$];
  int            wcyc  [2][$];
  int            done_cnt  [2];
  int            done_cyc  [2];
  int            stall_err [2];
  logic          prev_stall [2];
  logic [DW-1:0] prev_data  [2];

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (scan_valid[d] && scan_ready) begin
        words[d].push_back(scan_data[d]);
        wcyc[d].push_back(cyc);
      end
      if (scan_done[d]) begin
        done_cnt[d]++;
        done_cyc[d] = cyc;
      end
      if (prev_stall[d] && (!scan_valid[d] || scan_data[d] !== prev_data[d])) stall_err[d]++;
      prev_stall[d] = scan_valid[d] && !scan_ready;
      prev_data[d]  = scan_data[d];
    end
  end

  // CPU op table: write FFFF, write 1234 BE=01, read, write 5678 BE=10, write BE=00, read.
  bit            op_we  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [1:0]    op_be  [6] = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00};
  logic [DW-1:0] op_din [6] = '{16'hFFFF, 16'h1234, 16'h0000, 16'h5678, 16'h9999, 16'h0000};
  logic [DW-1:0] exp_r  [6] = '{16'hFFFF, 16'hFF34, 16'hFF34, 16'h5634, 16'h5634, 16'h5634};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mon();
    for (int d = 0; d < 2; d++) begin
      words[d].delete();
      wcyc[d].delete();
      done_cnt[d]   = 0;
      done_cyc[d]   = -1;
      stall_err[d]  = 0;
      prev_stall[d] = 1'b0;
    end
  endtask

  task automatic cpu_wr(input int a, input int v);
    cpu_req     = 1'b1;
    cpu_we      = 1'b1;
    cpu_be      = 2'b11;
    cpu_addr    = AB'(a);
    cpu_data_in = DW'(v);
    step();
  endtask

  task automatic scan_go(input int base, input int cnt);
    clr_mon();
    scan_base  = AB'(base);
    scan_count = (AB + 1)'(cnt);
    scan_start = 1'b1;
    t0         = cyc;
    step();
    scan_start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input bit toggle);
    int i;
    i = 0;
    while ((scan_busy[0] || scan_busy[1] || i < 2) && i < max_cyc) begin
      if (toggle) scan_ready = ~scan_ready;
      step();
      i++;
    end
    chk("scan_timeout", (i < max_cyc), 1'b1);
    step();
    step();
  endtask

  task automatic chk_all_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("%s_ack_d%0d", tag, d), cpu_ack[d], 0);
      chk($sformatf("%s_dout_d%0d", tag, d), cpu_data_out[d], 0);
      chk($sformatf("%s_valid_d%0d", tag, d), scan_valid[d], 0);
      chk($sformatf("%s_busy_d%0d", tag, d), scan_busy[d], 0);
      chk($sformatf("%s_done_d%0d", tag, d), scan_done[d], 0);
      chk($sformatf("%s_sdata_d%0d", tag, d), scan_data[d], 0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    int idx;
    int rl;
    reset_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_be = '0; cpu_addr = '0;
    cpu_data_in = '0; scan_start = 1'b0; scan_abort = 1'b0; scan_ready = 1'b0;
    scan_base = '0; scan_count = '0;
    clr_mon();
    repeat (3) step();
    chk_all_zero("por");
    reset_n = 1'b1;
    step();

    // Byte enables, write-first, ack latency and hold between acks.
    for (int m = 0; m <= 7; m++) begin
      if (m < 6) begin
        cpu_req = 1'b1; cpu_we = op_we[m]; cpu_be = op_be[m];
        cpu_addr = AB'(5); cpu_data_in = op_din[m];
      end else begin
        cpu_req = 1'b0;
      end
      step();
      for (int d = 0; d < 2; d++) begin
        idx = m - d;
        chk($sformatf("be_ack_m%0d_d%0d", m, d), cpu_ack[d], (idx >= 0 && idx < 6));
        if (idx >= 0) chk($sformatf("be_data_m%0d_d%0d", m, d), cpu_data_out[d],
                          exp_r[(idx < 6) ? idx : 5]);
      end
    end

    // Preload mem[i] = i.
    for (int i = 0; i < 32; i++) cpu_wr(i, i);
    for (int i = 1020; i < 1024; i++) cpu_wr(i, i);
    cpu_req = 1'b0;
    repeat (3) step();

    // Address wrap at full rate.
    scan_ready = 1'b1;
    scan_go(1022, 4);
    wait_idle(40, 1'b0);
    for (int d = 0; d < 2; d++) begin
      rl = d + 1;
      chk($sformatf("wrap_n_d%0d", d), words[d].size(), 4);
      for (int i = 0; i < 4; i++) begin
        if (i < words[d].size()) begin
          chk($sformatf("wrap_w%0d_d%0d", i, d), words[d][i], (1022 + i) % 1024);
          chk($sformatf("wrap_t%0d_d%0d", i, d), wcyc[d][i], t0 + rl + 2 + i);
        end
      end
      chk($sformatf("wrap_done_n_d%0d", d), done_cnt[d], 1);
      chk($sformatf("wrap_done_t_d%0d", d), done_cyc[d], t0 + rl + 6);
    end

    // Same-cycle CPU write to the address being scanned.
    scan_go(8, 4);
    step();
    step();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_be = 2'b11; cpu_addr = AB'(10); cpu_data_in = 16'hABCD;
    step();
    cpu_req = 1'b0;
    wait_idle(40, 1'b0);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("coll_n_d%0d", d), words[d].size(), 4);
      if (words[d].size() == 4) begin
        chk($sformatf("coll_w1_d%0d", d), words[d][1], 9);
        chk($sformatf("coll_w2_d%0d", d), words[d][2], 16'hABCD);
        chk($sformatf("coll_w3_d%0d", d), words[d][3], 11);
      end
    end

    // Backpressure with ready toggling.
    scan_ready = 1'b1;
    scan_go(16, 8);
    wait_idle(80, 1'b1);
    scan_ready = 1'b1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("bp_n_d%0d", d), words[d].size(), 8);
      for (int i = 0; i < 8; i++) begin
        if (i < words[d].size()) chk($sformatf("bp_w%0d_d%0d", i, d), words[d][i], 16 + i);
      end
      chk($sformatf("bp_stable_d%0d", d), stall_err[d], 0);
      chk($sformatf("bp_done_n_d%0d", d), done_cnt[d], 1);
      if (wcyc[d].size() > 0)
        chk($sformatf("bp_done_t_d%0d", d), done_cyc[d], wcyc[d][wcyc[d].size() - 1] + 1);
    end

    // Zero-length burst.
    scan_go(0, 0);
    repeat (3) step();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("zero_done_n_d%0d", d), done_cnt[d], 1);
      chk($sformatf("zero_done_t_d%0d", d), done_cyc[d], t0 + 1);
      chk($sformatf("zero_words_d%0d", d), words[d].size(), 0);
      chk($sformatf("zero_busy_d%0d", d), scan_busy[d], 0);
    end

    // START while busy is ignored.
    scan_go(0, 4);
    scan_base = AB'(20); scan_count = 11'd4; scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    wait_idle(40, 1'b0);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("busy_start_n_d%0d", d), words[d].size(), 4);
      if (words[d].size() == 4) chk($sformatf("busy_start_w3_d%0d", d), words[d][3], 3);
      chk($sformatf("busy_start_done_d%0d", d), done_cnt[d], 1);
    end

    // Abort during DUT0's third word.
    scan_go(0, 8);
    repeat (4) step();
    scan_abort = 1'b1;
    step();
    scan_abort = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("abort_valid_d%0d", d), scan_valid[d], 0);
      chk($sformatf("abort_busy_d%0d", d), scan_busy[d], 0);
    end
    repeat (8) step();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("abort_words_d%0d", d), words[d].size(), 3 - d);
      chk($sformatf("abort_nodone_d%0d", d), done_cnt[d], 0);
      chk($sformatf("abort_idle_d%0d", d), scan_busy[d], 0);
    end

    // ABORT beats a simultaneous START.
    clr_mon();
    scan_base = '0; scan_count = 11'd4; scan_abort = 1'b1; scan_start = 1'b1;
    step();
    scan_abort = 1'b0; scan_start = 1'b0;
    repeat (4) step();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("abort_start_busy_d%0d", d), scan_busy[d], 0);
      chk($sformatf("abort_start_words_d%0d", d), words[d].size(), 0);
      chk($sformatf("abort_start_done_d%0d", d), done_cnt[d], 0);
    end

    // Whole-memory burst (count = 2**ADDR_BITS).
    scan_go(0, 1024);
    wait_idle(1200, 1'b0);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("full_n_d%0d", d), words[d].size(), 1024);
      if (words[d].size() == 1024) begin
        chk($sformatf("full_w10_d%0d", d), words[d][10], 16'hABCD);
        chk($sformatf("full_w1023_d%0d", d), words[d][1023], 1023);
      end
      chk($sformatf("full_done_d%0d", d), done_cnt[d], 1);
    end

    // Reset held for two cycles in the middle of a stalled burst.
    scan_ready = 1'b0;
    scan_go(0, 8);
    repeat (5) step();
    for (int d = 0; d < 2; d++) chk($sformatf("pre_rst_valid_d%0d", d), scan_valid[d], 1);
    reset_n = 1'b0;
    step();
    chk_all_zero("rst1");
    step();
    chk_all_zero("rst2");
    reset_n = 1'b1;
    clr_mon();
    scan_ready = 1'b1;
    repeat (10) step();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("post_rst_words_d%0d", d), words[d].size(), 0);
      chk($sformatf("post_rst_done_d%0d", d), done_cnt[d], 0);
      chk($sformatf("post_rst_busy_d%0d", d), scan_busy[d], 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
